// File: rtl/p_accumulator.sv
// Frame accumulator: sums ACC_LEN accepted P samples into one saturating frame sum,
// delivered over a valid/ready handshake with an overflow flag.
module p_accumulator #(
    parameter int P_W     = 27,
    parameter int ACC_LEN = 8,
    parameter int SUM_W   = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic             clr,
    output logic [SUM_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             sum_ovf,
    output logic [7:0]       cnt,
    output logic [1:0]       fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // p_ready depends only on the registered state; sum_out/sum_ovf hold while sum_valid is 1.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(ACC_LEN - 1);

    state_t           state;
    logic [SUM_W-1:0] acc;
    logic             ovf_acc;
    logic [SUM_W:0]   add_full;
    logic             sat_hit;
    logic [SUM_W-1:0] add_sat;
    logic             accept;

    assign p_ready   = (state != HOLD);
    assign accept    = p_valid && p_ready;
    assign fsm_state = state;

    // ovf_acc is set only by saturation, so it doubles as the "already saturated" marker
    assign add_full = {1'b0, acc} + {{(SUM_W + 1 - P_W){1'b0}}, p_in};
    assign sat_hit  = add_full[SUM_W] | ovf_acc;
    assign add_sat  = sat_hit ? {SUM_W{1'b1}} : add_full[SUM_W-1:0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= 8'd0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            sum_ovf   <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= 8'd0;
            sum_valid <= 1'b0;
            sum_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            sum_out   <= add_sat;
                            sum_ovf   <= sat_hit;
                            sum_valid <= 1'b1;
                            acc       <= '0;
                            ovf_acc   <= 1'b0;
                            cnt       <= 8'd0;
                            state     <= HOLD;
                        end else begin
                            acc     <= add_sat;
                            ovf_acc <= sat_hit;
                            cnt     <= cnt + 8'd1;
                            state   <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        sum_ovf   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p_accumulator.sv
// Bench for p_accumulator: two instances (SUM_W 32 and 29) on shared stimulus,
// checked each cycle against a frame-level reference model plus a delivered-sum scoreboard.
module tb_p_accumulator;

    localparam int P_W     = 27;
    localparam int ACC_LEN = 8;

    logic             sys_clk;
    logic             sys_rst;
    logic [P_W-1:0]   p_in;
    logic             p_valid;
    logic             clr;
    logic             sum_ready;

    logic             p_ready_a, sum_valid_a, sum_ovf_a;
    logic [31:0]      sum_out_a;
    logic [7:0]       cnt_a;
    logic [1:0]       state_a;

    logic             p_ready_b, sum_valid_b, sum_ovf_b;
    logic [28:0]      sum_out_b;
    logic [7:0]       cnt_b;
    logic [1:0]       state_b;

    p_accumulator #(.P_W(P_W), .ACC_LEN(ACC_LEN), .SUM_W(32)) u_dut32 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .p_in(p_in), .p_valid(p_valid),
        .p_ready(p_ready_a), .clr(clr), .sum_out(sum_out_a), .sum_valid(sum_valid_a),
        .sum_ready(sum_ready), .sum_ovf(sum_ovf_a), .cnt(cnt_a), .fsm_state(state_a)
    );

    p_accumulator #(.P_W(P_W), .ACC_LEN(ACC_LEN), .SUM_W(29)) u_dut29 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .p_in(p_in), .p_valid(p_valid),
        .p_ready(p_ready_b), .clr(clr), .sum_out(sum_out_b), .sum_valid(sum_valid_b),
        .sum_ready(sum_ready), .sum_ovf(sum_ovf_b), .cnt(cnt_b), .fsm_state(state_b)
    );

    // clock / reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: frame contents as a list of samples, sums formed at frame end
    int unsigned frame_q[$];
    logic [31:0] exp_q[$];
    bit          m_pend;
    logic [63:0] m_sum32, m_sum29;
    bit          m_ovf32, m_ovf29;

    function automatic logic [63:0] sat_of(input logic [63:0] total, input int w);
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        return (total > max_v) ? max_v : total;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit pv,
                              input logic [P_W-1:0] pin, input bit sr);
        logic [63:0] total;
        if (r) begin
            frame_q.delete();
            exp_q.delete();
            m_pend  = 0;
            m_sum32 = 0;
            m_sum29 = 0;
            m_ovf32 = 0;
            m_ovf29 = 0;
        end else if (c) begin
            frame_q.delete();
            if (m_pend) void'(exp_q.pop_back());
            m_pend  = 0;
            m_ovf32 = 0;
            m_ovf29 = 0;
        end else if (m_pend) begin
            if (sr) begin
                m_pend  = 0;
                m_ovf32 = 0;
                m_ovf29 = 0;
            end
        end else if (pv) begin
            frame_q.push_back(int'(pin));
            if (frame_q.size() == ACC_LEN) begin
                total = 0;
                foreach (frame_q[i]) total += 64'(frame_q[i]);
                m_sum32 = sat_of(total, 32);
                m_sum29 = sat_of(total, 29);
                m_ovf32 = (total > 64'hFFFF_FFFF);
                m_ovf29 = (total > 64'h1FFF_FFFF);
                m_pend  = 1;
                exp_q.push_back(m_sum32[31:0]);
                frame_q.delete();
            end
        end
    endtask

    task automatic compare_outputs();
        check("p_ready32",   p_ready_a,   !m_pend);
        check("sum_valid32", sum_valid_a, m_pend);
        check("cnt32",       cnt_a,       frame_q.size());
        check("sum_out32",   sum_out_a,   m_sum32);
        check("sum_ovf32",   sum_ovf_a,   m_pend ? m_ovf32 : 1'b0);
        check("p_ready29",   p_ready_b,   !m_pend);
        check("sum_valid29", sum_valid_b, m_pend);
        check("cnt29",       cnt_b,       frame_q.size());
        check("sum_out29",   sum_out_b,   m_sum29);
        check("sum_ovf29",   sum_ovf_b,   m_pend ? m_ovf29 : 1'b0);
    endtask

    // driver: one clock cycle with the given inputs, then model update and compare
    task automatic drive(input bit r, input bit c, input bit pv,
                         input logic [P_W-1:0] pin, input bit sr);
        sys_rst   = r;
        clr       = c;
        p_valid   = pv;
        p_in      = pin;
        sum_ready = sr;
        #3;
        if (!r && !c && sum_valid_a && sum_ready) begin
            if (exp_q.size() == 0) check("deliver_unexpected", sum_out_a, 64'hDEAD);
            else check("deliver", sum_out_a, exp_q.pop_front());
        end
        @(posedge sys_clk);
        model_step(r, c, pv, pin, sr);
        #1;
        compare_outputs();
    endtask

    initial begin
        m_pend = 0; m_sum32 = 0; m_sum29 = 0; m_ovf32 = 0; m_ovf29 = 0;
        sys_rst = 1; clr = 0; p_valid = 0; p_in = '0; sum_ready = 0;
        @(posedge sys_clk);
        #1;
        drive(1, 0, 0, '0, 0);
        drive(1, 0, 0, '0, 0);
        check("rst_p_ready", p_ready_a, 1);
        check("rst_sum_out", sum_out_a, 0);
        check("rst_cnt", cnt_a, 0);

        // basic frame
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 27'd1000, 1);
        check("basic_sum", sum_out_a, 64'd8000);
        check("basic_hold_ready", p_ready_a, 0);
        drive(0, 0, 0, '0, 1);
        check("basic_after_ready", p_ready_a, 1);

        // gapped input
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, P_W'(i), 1);
            if (i < 8) drive(0, 0, 0, 27'd99, 1);
        end
        check("gapped_sum", sum_out_a, 64'd36);
        drive(0, 0, 0, '0, 1);

        // backpressure with saturation on the 29-bit instance
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 27'h7FF_FFFF, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 27'd7, 0);
        check("bp_sum32", sum_out_a, 64'h3FFF_FFF8);
        check("sat_sum29", sum_out_b, 64'h1FFF_FFFF);
        check("sat_ovf29", sum_ovf_b, 1);
        drive(0, 0, 1, 27'd7, 1);
        drive(0, 0, 1, 27'd1, 1);
        check("bp_first_counted", cnt_a, 1);
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 27'd1, 1);
        check("post_sat_sum29", sum_out_b, 64'd8);
        check("post_sat_ovf29", sum_ovf_b, 0);
        drive(0, 0, 0, '0, 1);

        // clr mid-frame, sample offered with clr is dropped
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 27'd50, 1);
        drive(0, 1, 1, 27'd50, 1);
        check("clr_cnt", cnt_a, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 27'd5, 1);
        check("clr_sum", sum_out_a, 64'd40);
        drive(0, 0, 0, '0, 1);

        // clr on the final accept, then clr together with sum_ready in HOLD
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 27'd2, 1);
        drive(0, 1, 1, 27'd2, 1);
        check("clr_final_valid", sum_valid_a, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 27'd3, 0);
        drive(0, 1, 0, '0, 1);
        check("clr_hold_valid", sum_valid_a, 0);

        // reset in HOLD
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 27'd4, 0);
        drive(0, 0, 0, '0, 0);
        drive(1, 0, 0, '0, 0);
        check("rst_hold_valid", sum_valid_a, 0);
        check("rst_hold_sum", sum_out_a, 0);
        check("rst_hold_ready", p_ready_a, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [P_W-1:0] v;
            v = ($urandom_range(0, 2) == 0) ? P_W'(27'h7FF_FFFF - $urandom_range(0, 5000))
                                            : P_W'($urandom_range(0, 1000));
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0);
        end

        check("sb_left", exp_q.size(), m_pend ? 1 : 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/p_accumulator.md
# p_accumulator

Downstream stage of the six-operand arithmetic top, which produces a 27-bit result P. The block consumes a stream of P results and sums ACC_LEN consecutive accepted samples into one frame sum. Each frame sum is delivered on a valid/ready output with saturation and an overflow flag. It closes the arithmetic path so that results are handed on as framed, flow-controlled values instead of free-running combinational outputs.

## Interface

Parameters:
- P_W, 27: width of the input sample; matches the upstream P output.
- ACC_LEN, 8: number of samples per frame; legal range 2..255.
- SUM_W, 32: width of the frame sum; must be ≥ P_W.

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  sole clock; every register updates on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- p_in  in  P_W  input sample, unsigned.
- p_valid  in  1  p_in is valid this cycle.
- p_ready  out  1  block can accept a sample this cycle; combinational from state only.
- clr  in  1  synchronous abort of the current frame.
- sum_out  out  SUM_W  frame sum, saturated.
- sum_valid  out  1  sum_out and sum_ovf are valid.
- sum_ready  in  1  downstream accepts sum_out.
- sum_ovf  out  1  the frame sum saturated.
- cnt  out  8  samples accepted in the current frame.

## Operation

- States:
  - IDLE: cnt = 0, no partial sum.
  - ACC: partial frame in progress.
  - HOLD: frame sum presented, waiting for downstream.
- p_ready is 1 in IDLE and ACC, and 0 in HOLD.
- Accept event: p_valid && p_ready at a rising edge.
  - Without an accept, acc, cnt and state hold.
- Accept with cnt < ACC_LEN-1:
  - acc ← sat(acc + zext(p_in)).
  - ovf_acc ← ovf_acc | carry.
  - cnt ← cnt+1.
  - State → ACC.
- Accept with cnt = ACC_LEN-1:
  - sum_out ← sat(acc + zext(p_in)).
  - sum_ovf ← ovf_acc | carry.
  - sum_valid ← 1.
  - acc, ovf_acc and cnt ← 0.
  - State → HOLD.
- Arithmetic:
  - Form the addition at SUM_W+1 bits.
  - If bit SUM_W is set, or acc was already saturated, the result is 2^SUM_W−1 and carry = 1.
  - The saturated value stays saturated for the rest of the frame.
- HOLD:
  - sum_out and sum_ovf are stable while sum_valid = 1.
  - When sum_valid && sum_ready: sum_valid ← 0 and state → IDLE.
  - sum_out keeps its last value; sum_ovf ← 0.
- clr (priority below sys_rst, above all else):
  - acc, ovf_acc, cnt ← 0; sum_valid ← 0; sum_ovf ← 0; state → IDLE.
  - Any sample offered in the same cycle is dropped.
  - A pending frame sum in HOLD is discarded.
- sys_rst:
  - Every register ← 0 and state → IDLE, in any state, including mid-frame and in HOLD.
- Reset values: p_ready = 1, sum_out = 0, sum_valid = 0, sum_ovf = 0, cnt = 0.

## Timing

- p_in is sampled only on accept edges; gaps in p_valid do not advance the frame.
- Latency: sum_valid rises on the edge that accepts the ACC_LEN-th sample, so it is visible the following cycle.
- p_ready falls in that same cycle.
- With sum_ready held at 1:
  - HOLD lasts exactly 1 cycle.
  - Peak throughput is one frame per ACC_LEN+1 cycles, i.e. one bubble per frame.
- No combinational path from sum_ready or p_valid to p_ready.
- Simultaneous clr and final accept: clr wins; no sum is produced.
- Simultaneous clr and sum_ready in HOLD: the sum is considered dropped, not delivered.
- cnt wraps only through the frame end, never past ACC_LEN-1.

## Test plan

- Basic frame:
  - Stimulus: reset, then p_in = 1000 with p_valid = 1 for 8 cycles, sum_ready = 1.
  - Response: sum_out = 8000 and sum_valid high for 1 cycle; sum_ovf = 0.
  - p_ready is 0 exactly in that cycle; cnt runs 0..7 then returns to 0.
- Gapped input:
  - Stimulus: samples 1..8 with p_valid toggling 1,0,1,0…
  - Response: sum_out = 36 after the 8th valid sample; cnt advances only on valid cycles.
- Backpressure:
  - Stimulus: 8 samples of 0x7FFFFFF with sum_ready = 0 for 5 cycles after sum_valid.
  - Response: sum_out = 0x3FFFFFF8 stable for those cycles; p_ready = 0.
  - Further p_valid pulses are ignored.
  - After sum_ready = 1, one more cycle passes, then a new frame starts and its first sample is counted.
- Saturation, with SUM_W = 29:
  - Stimulus: 8 samples of 0x7FFFFFF.
  - Response: sum_out = 0x1FFFFFFF and sum_ovf = 1.
  - The next frame of 8 samples of 1 gives sum_out = 8 and sum_ovf = 0.
- clr mid-frame:
  - Stimulus: 3 samples of 50, clr for 1 cycle, then 8 samples of 5.
  - Response: a single sum_out = 40; cnt returns to 0 the cycle after clr.
- Reset in HOLD:
  - Stimulus: assert sys_rst while sum_valid = 1 and sum_ready = 0.
  - Response: the next cycle shows sum_valid = 0, sum_out = 0, cnt = 0 and p_ready = 1.
